// File: rtl/pulse_trig_sched.sv
// pulse_trig_sched
//   Time-triggered pulse command scheduler. Entries (command, register
//   operand, fire time) are queued in a small circular buffer. The head entry
//   is compared against a free-running time counter (qclk); when it is due it
//   is popped and presented on the outputs with a one-cycle write enable and
//   strobe in the following cycle. A head whose time has already passed is
//   either fired and flagged (HALT_ON_LATE=0) or flagged and frozen in HALT
//   until flush (HALT_ON_LATE=1).
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   cmd_in/reg_in        : command word and operand to enqueue
//   cmd_time             : qclk value at which the entry fires
//   cmd_valid/cmd_ready  : enqueue handshake
//   sync                 : clears qclk on the next cycle
//   flush                : empties the queue, leaves HALT
//   pulse_cmd_out/reg_out: last fired entry (held between fires)
//   pulse_write_en       : one-cycle write enable per fired entry
//   cstrobe_out          : one-cycle strobe, coincident with pulse_write_en
//   qclk                 : free-running time counter
//   count                : number of queued entries
//   late_err             : sticky late-entry flag, cleared only by reset
//   halted               : high while in HALT
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | queue empty, nothing to compare
// WAIT   | head entry pending, compared against qclk every cycle
// HALT   | late head seen with HALT_ON_LATE=1; frozen until flush/reset

module pulse_trig_sched #(
  parameter int CMD_WIDTH    = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int TIME_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter bit HALT_ON_LATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CMD_WIDTH-1:0]    cmd_in,
  input  logic [DATA_WIDTH-1:0]   reg_in,
  input  logic [TIME_WIDTH-1:0]   cmd_time,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    sync,
  input  logic                    flush,
  output logic [CMD_WIDTH-1:0]    pulse_cmd_out,
  output logic [DATA_WIDTH-1:0]   reg_out,
  output logic                    pulse_write_en,
  output logic                    cstrobe_out,
  output logic [TIME_WIDTH-1:0]   qclk,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    late_err,
  output logic                    halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]           DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]           CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]         PTR_ONE = AW'(1);
  localparam logic [TIME_WIDTH-1:0] T_ONE   = TIME_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [TIME_WIDTH-1:0]  qclk_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;

  logic [CMD_WIDTH-1:0]   cmd_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  reg_mem_q  [DEPTH];
  logic [TIME_WIDTH-1:0]  time_mem_q [DEPTH];

  logic [CMD_WIDTH-1:0]   pulse_cmd_q;
  logic [DATA_WIDTH-1:0]  reg_out_q;
  logic                   write_en_q;
  logic                   cstrobe_q;
  logic                   late_err_q;

  logic [TIME_WIDTH-1:0]  diff;
  logic                   head_valid;
  logic                   head_due;
  logic                   head_late;
  logic                   push;
  logic                   pop;
  logic                   halt_go;

  // Head is read straight from the buffer; count_q only rises the cycle after
  // a push, so a new entry is never compared in its own push cycle.
  always_comb begin
    diff       = time_mem_q[rd_ptr_q] - qclk_q;
    head_valid = (state_q == ST_WAIT) && (count_q != '0);
    head_due   = (diff == '0);
    head_late  = diff[TIME_WIDTH-1];
    cmd_ready  = (count_q < DEPTH_C) && (state_q != ST_HALT);
    push       = cmd_valid && cmd_ready && !flush;
    pop        = head_valid && !flush && (head_due || (head_late && !HALT_ON_LATE));
    halt_go    = head_valid && !flush && head_late && HALT_ON_LATE;
  end

  // Time counter and queue bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      qclk_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      qclk_q <= sync ? '0 : qclk_q + T_ONE;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      cmd_mem_q[wr_ptr_q]  <= cmd_in;
      reg_mem_q[wr_ptr_q]  <= reg_in;
      time_mem_q[wr_ptr_q] <= cmd_time;
    end
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pulse_cmd_q <= '0;
      reg_out_q   <= '0;
      write_en_q  <= 1'b0;
      cstrobe_q   <= 1'b0;
      late_err_q  <= 1'b0;
    end else begin
      write_en_q <= pop;
      cstrobe_q  <= pop;
      if (pop) begin
        pulse_cmd_q <= cmd_mem_q[rd_ptr_q];
        reg_out_q   <= reg_mem_q[rd_ptr_q];
      end
      if ((pop && head_late) || halt_go) late_err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (push) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush)
            state_q <= ST_IDLE;
          else if (halt_go)
            state_q <= ST_HALT;
          else if (pop && !push && (count_q == CNT_ONE))
            state_q <= ST_IDLE;
        end
        ST_HALT: begin
          if (flush) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pulse_cmd_out  = pulse_cmd_q;
  assign reg_out        = reg_out_q;
  assign pulse_write_en = write_en_q;
  assign cstrobe_out    = cstrobe_q;
  assign qclk           = qclk_q;
  assign count          = count_q;
  assign late_err       = late_err_q;
  assign halted         = (state_q == ST_HALT);

endmodule

// File: doc/pulse_trig_sched.md
PULSE_TRIG_SCHED -- requirements
Module: pulse_trig_sched

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 64: width of one pulse command word, passed through unmodified.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the register operand queued with each command.
REQ-003 SHALL have parameter TIME_WIDTH, default 32: width of the trigger timestamp and of qclk.
REQ-004 SHALL have parameter DEPTH, default 4: queue depth; must be a power of two, at least 2.
REQ-005 SHALL have parameter HALT_ON_LATE, default 0: when 1, a late entry halts the scheduler instead of firing.
REQ-006 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-008 SHALL have port cmd_in  in  CMD_WIDTH: pulse command to enqueue.
REQ-009 SHALL have port reg_in  in  DATA_WIDTH: register operand enqueued with cmd_in.
REQ-010 SHALL have port cmd_time  in  TIME_WIDTH: qclk value at which the entry fires.
REQ-011 SHALL have port cmd_valid  in  1: enqueue request.
REQ-012 SHALL have port cmd_ready  out  1: queue can accept an entry.
REQ-013 SHALL have port sync  in  1: clears qclk.
REQ-014 SHALL have port flush  in  1: empties the queue and leaves HALT.
REQ-015 SHALL have port pulse_cmd_out  out  CMD_WIDTH: command of the fired entry.
REQ-016 SHALL have port reg_out  out  DATA_WIDTH: operand of the fired entry.
REQ-017 SHALL have port pulse_write_en  out  1: one-cycle write enable to the pulse register block.
REQ-018 SHALL have port cstrobe_out  out  1: one-cycle strobe, coincident with pulse_write_en.
REQ-019 SHALL have port qclk  out  TIME_WIDTH: free-running time counter.
REQ-020 SHALL have port count  out  clog2(DEPTH)+1: number of entries currently queued.
REQ-021 SHALL have port late_err  out  1: sticky late-entry flag.
REQ-022 SHALL have port halted  out  1: high while in HALT.

Function
REQ-023 SHALL increment qclk by 1 every cycle, modulo 2^TIME_WIDTH; when sync is high, qclk SHALL be 0 on the next cycle.
REQ-024 SHALL drive cmd_ready = (count < DEPTH) and not halted; a push SHALL occur when cmd_valid and cmd_ready are both high, and cmd_valid while not ready SHALL be ignored.
REQ-025 SHALL make a pushed entry visible at the queue head no earlier than the cycle after the push.
REQ-026 SHALL form diff = head_time - qclk, modulo 2^TIME_WIDTH: diff == 0 means due; diff MSB set means late.
REQ-027 SHALL implement states IDLE (queue empty), WAIT (head pending) and HALT.
- IDLE -> WAIT when count becomes nonzero.
- WAIT -> IDLE when the last entry pops and no push occurs in the same cycle.
- WAIT -> HALT on a late head when HALT_ON_LATE=1.
- HALT -> IDLE only on flush or reset.
REQ-028 SHALL pop a due head in WAIT; in the cycle after the pop it SHALL drive pulse_cmd_out, reg_out from the popped entry and pulse_write_en = cstrobe_out = 1 for exactly one cycle.
REQ-029 SHALL, for a late head with HALT_ON_LATE=0, fire it as in REQ-028 and set late_err.
REQ-030 SHALL, for a late head with HALT_ON_LATE=1, set late_err, leave the entry queued and not fire it.
REQ-031 SHALL support firing entries with consecutive timestamps on consecutive cycles, with no bubble.
REQ-032 SHALL, on a push and a pop in the same cycle, leave count unchanged.
REQ-033 SHALL, on flush, set count to 0 on the next cycle, suppress any pop in that cycle and ignore a push in that cycle; flush SHALL NOT clear late_err or qclk.
REQ-034 SHALL hold pulse_cmd_out and reg_out at their last fired values between fires.
REQ-035 SHALL clear late_err only on reset.

Reset
REQ-036 SHALL, on reset, set qclk=0, count=0, state IDLE, pulse_write_en=0, cstrobe_out=0, late_err=0, halted=0, pulse_cmd_out=0 and reg_out=0.
REQ-037 SHALL give reset priority over sync, flush and push; an in-flight fire SHALL be cancelled, so no strobe appears in the cycle after reset.

Verification
REQ-038 SHALL cover: reset, then push at qclk=2 with cmd_time=10 -> single strobe in the cycle where qclk=11 with the pushed cmd, count back to 0.
REQ-039 SHALL cover: push times 20, 21, 22 -> strobes on three consecutive cycles, in order, with late_err=0.
REQ-040 SHALL cover: DEPTH=4, push 5 entries back-to-back -> cmd_ready low after the 4th push, 5th entry dropped, count=4.
REQ-041 SHALL cover: HALT_ON_LATE=0, push cmd_time=3 at qclk=8 -> fires within 2 cycles, late_err=1; with HALT_ON_LATE=1 -> no strobe, halted=1, cmd_ready=0, and flush returns to IDLE with count=0.
REQ-042 SHALL cover: qclk preloaded near 2^32-2 via sync timing, entry cmd_time=1 -> fires after wrap, not flagged late.
REQ-043 SHALL cover: reset asserted in the cycle a head is due -> no strobe, all outputs at reset values.
